fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch front end for the RISC-V core, on the opposite side of the control decoder's PCSrc interface.
- Owns the architectural PC and issues word reads to instruction memory over a single-outstanding req/ready/rvalid port.
- Presents each fetched instruction to the decode stage with a valid/ready handshake.
- Applies the decoder's PC selection: sequential, branch/jal target, or jalr target. An external flush (trap/debug) may redirect fetch at any time.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr while not valid (addi x0,x0,0)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  memory accepts request this cycle (imem_req & imem_ready = handshake)
- imem_rvalid  input  1  read data valid, at least one cycle after the accept
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr/pc hold a live instruction
- instr_ready  input  1  decode consumes the instruction this cycle
- instr  output  32  fetched instruction
- pc  output  32  address of instr
- pc_plus4  output  32  pc + 4, combinational
- pc_src  input  2  decoder PC select, sampled on consume: 00 pc+4, 01 branch_target, 10 jalr_target, 11 reserved (treated as 00)
- branch_target  input  32  pc + immediate (branch/jal)
- jalr_target  input  32  ALU result for jalr
- flush_valid  input  1  asynchronous-to-pipeline redirect request
- flush_pc  input  32  redirect address
- fetch_fault  output  1  sticky, next PC misaligned

Behaviour:
- Reset (synchronous, any state, mid-transaction included):
  - state=IDLE; fetch_pc=RESET_PC; pc=RESET_PC; instr=NOP_INSTR; instr_valid=0; imem_req=0; imem_addr=RESET_PC; fetch_fault=0; kill=0.
  - An rvalid arriving after reset for a pre-reset request is ignored; kill is not needed for this because WAIT is not entered.
- IDLE: one cycle, then REQ.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - On imem_ready, go to WAIT.
  - While not accepted, imem_addr is stable unless a flush occurs.
- WAIT: imem_req=0.
  - On imem_rvalid with kill=0: instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, go to HOLD.
  - On imem_rvalid with kill=1: discard data, kill<=0, go to REQ.
- HOLD: instr_valid=1, instr/pc stable until instr_ready.
  - On instr_ready, compute next = pc+4 (pc_src 00/11), branch_target (01), or {jalr_target[31:1],1'b0} (10).
  - Then fetch_pc<=next, instr_valid<=0, instr<=NOP_INSTR, go to REQ.
- Misalignment: if the selected next PC or flush_pc has bits[1:0]!=0:
  - fetch_fault<=1, state FAULT, no request issued, instr_valid=0.
  - FAULT exits only on reset.
  - A flush while in FAULT is ignored.
- Flush (highest priority, one-cycle pulse):
  - IDLE/REQ not accepted: fetch_pc<=flush_pc, state REQ. The new address is on imem_addr next cycle.
  - REQ accepted same cycle, or WAIT without rvalid: kill<=1, fetch_pc<=flush_pc, stay in / go to WAIT.
  - WAIT with rvalid same cycle: discard data, fetch_pc<=flush_pc, go to REQ.
  - HOLD: instruction dropped (instr_valid<=0) even if instr_ready is high the same cycle; pc_src is ignored; fetch_pc<=flush_pc, go to REQ.
- Only one request is outstanding at a time; no prefetch.
- Throughput with a zero-wait memory (ready in the request cycle, rvalid next cycle) and decode always ready: one instruction every 3 cycles.
- Arithmetic: all PC math is 32-bit modulo 2^32. pc=32'hFFFF_FFFC with pc_src=00 wraps to 32'h0000_0000 with no fault.

Test Plan:
- Reset release, zero-wait memory returning rdata=addr, instr_ready=1: imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every 3rd cycle; pc matches imem_addr.
- At pc=0x10, pc_src=01, branch_target=0x40 on consume, then pc_src=10, jalr_target=0x81: next fetches go to 0x40, then 0x80 (bit0 cleared).
- Memory with 3-cycle rvalid delay, flush_pc=0x200 pulsed in the cycle after accept: old data discarded, next imem_addr=0x200, first instr_valid carries pc=0x200.
- instr_ready held low 5 cycles in HOLD: instr/pc stable, imem_req=0 throughout; consume then resumes at pc+4.
- pc_src=01 with branch_target=0x102: fetch_fault=1, imem_req stays 0, a later flush is ignored; reset clears fault and refetches RESET_PC.
- Reset asserted in WAIT, stale rvalid arriving the cycle after reset deasserts: data ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch front end. Owns the architectural PC, issues one word
// read at a time to instruction memory and hands each fetched instruction
// to decode with a valid/ready handshake. The next PC comes from the
// decoder's pc_src select when decode consumes the instruction. A flush
// redirects fetch from any state except FAULT.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req/addr       fetch request and word-aligned address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   read data return (one outstanding request)
//   instr_valid/ready   handshake with decode
//   instr, pc           fetched instruction and its address
//   pc_plus4            pc + 4, combinational
//   pc_src              00/11 pc+4, 01 branch_target, 10 jalr_target
//   branch_target       pc + immediate for branch/jal
//   jalr_target         ALU result for jalr (bit 0 cleared here)
//   flush_valid/pc      one-cycle redirect request
//   fetch_fault         sticky: a misaligned next PC was selected
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        kill_q, kill_d;

  logic [31:0] sel_pc;
  logic        sel_bad;
  logic        flush_bad;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_fault = fault_q;

  // Next-PC select applied when decode consumes; jalr targets lose bit 0.
  always_comb begin
    sel_pc = pc_plus4;
    case (pc_src)
      2'b01:   sel_pc = branch_target;
      2'b10:   sel_pc = {jalr_target[31:1], 1'b0};
      default: sel_pc = pc_plus4;
    endcase
  end

  assign sel_bad   = (sel_pc[1:0] != 2'b00);
  assign flush_bad = (flush_pc[1:0] != 2'b00);

  // Next-state logic. A flush always wins over the normal transition of the
  // current state. kill marks an accepted request whose data must be thrown
  // away because a flush redirected fetch while it was in flight.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    kill_d        = kill_q;

    case (state_q)
      IDLE: begin
        if (flush_valid && flush_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          if (flush_valid) fetch_pc_d = flush_pc;
          state_d = REQ;
        end
      end

      REQ: begin
        if (flush_valid && flush_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (flush_valid) begin
          fetch_pc_d = flush_pc;
          if (imem_ready) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (flush_valid && flush_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
          kill_d  = 1'b0;
        end else if (flush_valid) begin
          fetch_pc_d = flush_pc;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = fetch_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end

      HOLD: begin
        if (flush_valid || instr_ready) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (flush_valid ? flush_bad : sel_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            fetch_pc_d = flush_valid ? flush_pc : sel_pc;
            state_d    = REQ;
          end
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      kill_q        <= kill_d;
    end
  end

endmodule
